jam_gen: RTL and testbench
==========================

JAM_GEN -- requirements
Module: jam_gen

Interface
REQ-001 Parameter N, default 8: number of workers and jobs, legal range 2..8.
REQ-002 Parameter CW, default 7: width of each unsigned cost entry.
REQ-003 Derived constants: SW = CW+$clog2(N)+1 (sum width) and JW = $clog2(N)+1 (job id width, holds 1..N).
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  1: high while cost entries are presented.
REQ-007 in_cost  input  CW: cost entry, row-major order; beat k = worker k/N, job k%N.
REQ-008 in_mode  input  1: 0 = minimise, 1 = maximise; sampled only on the first beat.
REQ-009 out_valid  output  1: high for exactly N consecutive result cycles.
REQ-010 out_job  output  JW: 1-based job assigned to worker k on the k-th result cycle.
REQ-011 out_cost  output  SW: best total cost, held constant for all N result cycles.

Function
REQ-012 States: IDLE, INPUT, SEARCH, OUT.
REQ-013 IDLE->INPUT on in_valid=1; that beat is stored as entry 0 and in_mode is latched.
REQ-014 INPUT->SEARCH on the cycle that stores beat N*N-1.
REQ-015 INPUT->IDLE if in_valid=0 before beat N*N-1; the partial matrix is discarded and out_valid stays low.
REQ-016 SEARCH: one permutation p is evaluated per cycle, where p[w] = job index of worker w.
REQ-017 SEARCH order: lexicographic, starting at the identity and ending at the descending permutation (N! cycles).
REQ-018 Cost of p = sum over w of cost[w][p[w]], computed at full SW width without overflow.
REQ-019 Best-cost register initialises to all-ones in minimise mode and to zero in maximise mode.
REQ-020 Best update uses strict < (minimise) or strict > (maximise), so ties keep the lexicographically first permutation.
REQ-021 SEARCH->OUT on the cycle that evaluates the descending permutation; that permutation is still compared.
REQ-022 OUT lasts N cycles, then returns to IDLE.
REQ-023 Outputs are registered; out_valid first rises N!+2 rising edges after the edge that samples the last in_cost.
REQ-024 While out_valid=0, out_job and out_cost SHALL be 0.
REQ-025 in_valid is ignored in SEARCH and OUT; a new input may start on the first cycle after out_valid falls.
REQ-026 Permutation, best list and best cost are reinitialised on every IDLE->INPUT transition; no state carries across jobs.

Reset
REQ-027 rst_n low SHALL asynchronously force all of the following: state=IDLE; beat counter=0; cost matrix=0; permutation=identity; best list=identity; best cost=all-ones; out_valid=0, out_job=0, out_cost=0.
REQ-028 Reset asserted mid-INPUT or mid-SEARCH abandons the job; no out_valid pulse follows reset release.

Structure
REQ-029 Package jam_gen_pkg SHALL hold the state enum, default N/CW, and the SW/JW width functions.
REQ-030 Next-permutation logic SHALL be a combinational sub-module jam_perm_next (parameter N).
REQ-031 jam_perm_next computes pivot search, successor swap and suffix reversal for any N.
REQ-032 Cost summation SHALL be a balanced adder tree inside jam_gen.

Verification
REQ-033 N=8, min, cost[w][j]=0 on the diagonal and 10 elsewhere -> out_cost=0, out_job=1..8, out_valid at exactly 40322 edges.
REQ-034 N=8, min, all entries 5 -> out_cost=40, out_job=1,2,...,8 (tie keeps the identity).
REQ-035 N=3, max, cost[w][j]=w*3+j, ties broken lexicographically -> out_cost=12, out_job=1,2,3, out_valid at 8 edges, lasting 3 cycles.
REQ-036 N=8, in_valid dropped after 20 beats -> IDLE, no out_valid; a following full matrix produces a correct result.
REQ-037 rst_n pulsed mid-SEARCH -> all outputs 0 immediately, no out_valid afterwards; a new matrix is then processed correctly.
REQ-038 Back-to-back jobs (min, then max on a different matrix) -> second result is independent of the first.

Source files
------------

// File: rtl/jam_gen_pkg.sv
// Shared types and width helpers for the exhaustive assignment solver.
package jam_gen_pkg;

  typedef enum logic [1:0] {StIdle, StInput, StSearch, StOut} state_e;

  localparam int unsigned DefN  = 8;
  localparam int unsigned DefCw = 7;

  function automatic int unsigned sum_width(input int unsigned n, input int unsigned cw);
    return cw + $clog2(n) + 1;
  endfunction

  function automatic int unsigned job_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/jam_perm_next.sv
// Combinational lexicographic successor of a permutation of 0..N-1.
module jam_perm_next #(
  parameter int unsigned N = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0][IW-1:0] perm,
  output logic [N-1:0][IW-1:0] perm_next,
  output logic                 is_last
);

  logic [IW-1:0]         pivot;
  logic [IW-1:0]         succ;
  logic [N-1:0][IW-1:0]  swapped;

  always_comb begin
    pivot   = '0;
    is_last = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i] < perm[i + 1]) begin
        pivot   = IW'(i);
        is_last = 1'b0;
      end
    end

    // Rightmost element above the pivot value; the suffix is descending.
    succ = IW'(N - 1);
    for (int j = 0; j < N; j++) begin
      if (j > int'(pivot) && perm[j] > perm[pivot]) begin
        succ = IW'(j);
      end
    end

    swapped        = perm;
    swapped[pivot] = perm[succ];
    swapped[succ]  = perm[pivot];

    perm_next = swapped;
    for (int k = 0; k < N; k++) begin
      if (k > int'(pivot)) begin
        perm_next[k] = swapped[IW'(N + int'(pivot) - k)];
      end
    end
  end

endmodule

// File: rtl/jam_gen.sv
// Brute-force N x N assignment solver: loads a cost matrix, scans all N!
// permutations in lexicographic order and streams out the best job list.
module jam_gen
  import jam_gen_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned CW = DefCw,
  localparam int unsigned SW = sum_width(N, CW),
  localparam int unsigned JW = job_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_cost,
  input  logic          in_mode,
  output logic          out_valid,
  output logic [JW-1:0] out_job,
  output logic [SW-1:0] out_cost
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned NN = N * N;
  localparam int unsigned BW = $clog2(NN);
  localparam int unsigned P  = 2 ** IW;

  typedef logic [N-1:0][IW-1:0] perm_t;

  function automatic perm_t identity();
    perm_t p;
    for (int w = 0; w < N; w++) p[w] = IW'(w);
    return p;
  endfunction

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q;
  logic [CW-1:0] cost_q [N][N];
  logic          mode_q;
  perm_t         perm_q, best_q, perm_nxt;
  logic          perm_last;
  logic [SW-1:0] best_cost_q, perm_sum;
  logic          better;
  logic [IW-1:0] oc_q;
  logic          stg_valid_q;
  logic [JW-1:0] stg_job_q;
  logic [SW-1:0] stg_cost_q;
  logic          first_beat, last_beat;
  logic [IW-1:0] row, col;

  assign row = IW'(beat_q / BW'(N));
  assign col = IW'(beat_q % BW'(N));

  // A new job is held off while the final result beat is still on the output.
  assign first_beat = (state_q == StIdle) && in_valid && !out_valid;
  assign last_beat  = (state_q == StInput) && in_valid && (beat_q == BW'(NN - 1));

  jam_perm_next #(
    .N(N)
  ) u_perm_next (
    .perm      (perm_q),
    .perm_next (perm_nxt),
    .is_last   (perm_last)
  );

  always_comb begin : p_sum_tree
    logic [SW-1:0] node [2*P];
    for (int i = 0; i < 2 * P; i++) node[i] = '0;
    for (int w = 0; w < N; w++) node[P + w] = SW'(cost_q[w][perm_q[w]]);
    for (int i = P - 1; i >= 1; i--) node[i] = node[2 * i] + node[2 * i + 1];
    perm_sum = node[1];
  end

  assign better = mode_q ? (perm_sum > best_cost_q) : (perm_sum < best_cost_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (first_beat) state_d = StInput;
      StInput: begin
        if (!in_valid)      state_d = StIdle;
        else if (last_beat) state_d = StSearch;
      end
      StSearch: if (perm_last) state_d = StOut;
      StOut:    if (oc_q == IW'(N - 1)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      mode_q      <= 1'b0;
      perm_q      <= identity();
      best_q      <= identity();
      best_cost_q <= '1;
      oc_q        <= '0;
      for (int w = 0; w < N; w++) begin
        for (int j = 0; j < N; j++) cost_q[w][j] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (first_beat) begin
            cost_q[0][0] <= in_cost;
            beat_q       <= BW'(1);
            mode_q       <= in_mode;
            perm_q       <= identity();
            best_q       <= identity();
            best_cost_q  <= {SW{~in_mode}};
            oc_q         <= '0;
          end
        end
        StInput: begin
          if (in_valid) begin
            cost_q[row][col] <= in_cost;
            beat_q           <= beat_q + 1'b1;
          end
        end
        StSearch: begin
          perm_q <= perm_nxt;
          if (better) begin
            best_q      <= perm_q;
            best_cost_q <= perm_sum;
          end
        end
        StOut:   oc_q <= oc_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Two output stages: the first snapshots the result so a new job may
  // reinitialise the search registers while the last beat is still leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_job_q   <= '0;
      stg_cost_q  <= '0;
      out_valid   <= 1'b0;
      out_job     <= '0;
      out_cost    <= '0;
    end else begin
      stg_valid_q <= (state_q == StOut);
      stg_job_q   <= (state_q == StOut) ? JW'(best_q[oc_q]) + JW'(1) : '0;
      stg_cost_q  <= (state_q == StOut) ? best_cost_q : '0;
      out_valid   <= stg_valid_q;
      out_job     <= stg_job_q;
      out_cost    <= stg_cost_q;
    end
  end

endmodule

// File: tb/tb_jam_gen.sv
// Self-checking bench for jam_gen at N=8, N=4 and N=3 against a rank-order
// brute-force reference.
module tb_jam_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, rst4_n;
  logic [2:0]      iv, im;
  logic [2:0][6:0] ic;

  logic ov8; logic [3:0] oj8; logic [10:0] oc8;
  logic ov4; logic [2:0] oj4; logic [9:0]  oc4;
  logic ov3; logic [2:0] oj3; logic [9:0]  oc3;

  wire [2:0]       ov = {ov3, ov4, ov8};
  wire [2:0][3:0]  oj = {{1'b0, oj3}, {1'b0, oj4}, oj8};
  wire [2:0][10:0] oc = {{1'b0, oc3}, {1'b0, oc4}, oc8};

  jam_gen #(.N(8), .CW(7)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_cost(ic[0]), .in_mode(im[0]),
    .out_valid(ov8), .out_job(oj8), .out_cost(oc8)
  );
  jam_gen #(.N(4), .CW(7)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(iv[1]), .in_cost(ic[1]), .in_mode(im[1]),
    .out_valid(ov4), .out_job(oj4), .out_cost(oc4)
  );
  jam_gen #(.N(3), .CW(7)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_cost(ic[2]), .in_mode(im[2]),
    .out_valid(ov3), .out_job(oj3), .out_cost(oc3)
  );

  int total = 0;
  int bad   = 0;
  int unsigned mat [8][8];
  int exp_cost;
  int exp_job [8];

  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f *= i;
    return f;
  endfunction

  function automatic int nsz(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 4 : 3;
  endfunction

  // Walks permutations by rank (factorial number system), which is
  // lexicographic order; only strict improvements replace the incumbent.
  task automatic model(input int n, input bit mx);
    int f, rem, s, idx, d;
    int p [8];
    int avail [$];
    f = fact(n);
    for (int r = 0; r < f; r++) begin
      avail.delete();
      for (int j = 0; j < n; j++) avail.push_back(j);
      rem = r;
      for (int w = 0; w < n; w++) begin
        d   = fact(n - 1 - w);
        idx = rem / d;
        rem = rem % d;
        p[w] = avail[idx];
        avail.delete(idx);
      end
      s = 0;
      for (int w = 0; w < n; w++) s += int'(mat[w][p[w]]);
      if (r == 0 || (mx ? (s > exp_cost) : (s < exp_cost))) begin
        exp_cost = s;
        for (int w = 0; w < n; w++) exp_job[w] = p[w] + 1;
      end
    end
  endtask

  task automatic fill_random(input int n, input int unsigned hi);
    for (int w = 0; w < n; w++)
      for (int j = 0; j < n; j++) mat[w][j] = $urandom_range(hi, 0);
  endtask

  // Entered and left on a negedge; beat k is driven at the k-th negedge.
  task automatic drive_matrix(input int sel, input int n, input bit mx, input int beats);
    for (int k = 0; k < beats; k++) begin
      if (k > 0) @(negedge clk);
      iv[sel] = 1'b1;
      ic[sel] = 7'(mat[k / n][k % n]);
      im[sel] = (k == 0) ? mx : 1'($urandom);
    end
  endtask

  task automatic run_job(input int sel, input bit mx, input string tag);
    int n, f, cnt;
    bit idle_dirty;
    n = nsz(sel);
    f = fact(n);
    drive_matrix(sel, n, mx, n * n);
    @(posedge clk);
    @(negedge clk);
    iv[sel] = 1'b0; ic[sel] = '0; im[sel] = 1'b0;
    model(n, mx);
    cnt = 0;
    idle_dirty = 1'b0;
    while (cnt < f + 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (ov[sel]) break;
      if (oj[sel] != 0 || oc[sel] != 0) idle_dirty = 1'b1;
    end
    total++;
    if (!ov[sel] || cnt != f + 2) begin
      bad++;
      $display("FAIL %s latency: got %0d edges (valid=%0b) want %0d", tag, cnt, ov[sel], f + 2);
      return;
    end
    total++;
    if (idle_dirty) begin
      bad++;
      $display("FAIL %s idle outputs: got nonzero want 0", tag);
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (ov[sel] !== 1'b1 || oj[sel] !== 4'(exp_job[k])) begin
        bad++;
        $display("FAIL %s job[%0d]: got valid=%0b job=%0d want valid=1 job=%0d",
                 tag, k, ov[sel], oj[sel], exp_job[k]);
      end
      total++;
      if (oc[sel] !== 11'(exp_cost)) begin
        bad++;
        $display("FAIL %s cost[%0d]: got %0d want %0d", tag, k, oc[sel], exp_cost);
      end
    end
    @(negedge clk);
    total++;
    if (ov[sel] !== 1'b0 || oj[sel] !== 4'd0 || oc[sel] !== 11'd0) begin
      bad++;
      $display("FAIL %s end: got valid=%0b job=%0d cost=%0d want 0 0 0",
               tag, ov[sel], oj[sel], oc[sel]);
    end
  endtask

  task automatic expect_quiet(input int sel, input int cycles, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (ov[sel] !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL %s quiet: got out_valid pulse want none", tag);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (ov[s] !== 1'b0 || oj[s] !== 4'd0 || oc[s] !== 11'd0) begin
        bad++;
        $display("FAIL reset[%0d]: got valid=%0b job=%0d cost=%0d want 0 0 0",
                 s, ov[s], oj[s], oc[s]);
      end
    end
  endtask

  task automatic test_diag8();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) mat[w][j] = (w == j) ? 0 : 10;
    run_job(0, 1'b0, "diag8");
  endtask

  task automatic test_abort_then_uniform8();
    fill_random(8, 127);
    drive_matrix(0, 8, 1'b0, 20);
    @(negedge clk);
    iv[0] = 1'b0;
    expect_quiet(0, 40, "abort8");
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) mat[w][j] = 5;
    run_job(0, 1'b0, "uniform8");
  endtask

  task automatic test_max3();
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) mat[w][j] = w * 3 + j;
    run_job(2, 1'b1, "max3");
  endtask

  task automatic test_random();
    int sel;
    for (int it = 0; it < 8; it++) begin
      sel = (it % 2 == 0) ? 1 : 2;
      fill_random(nsz(sel), (it % 3 == 0) ? 2 : 127);
      run_job(sel, 1'($urandom), $sformatf("rand%0d", it));
    end
  endtask

  task automatic test_reset_mid_search();
    int c;
    fill_random(4, 127);
    drive_matrix(1, 4, 1'b0, 16);
    @(posedge clk);
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (5) @(negedge clk);
    rst4_n = 1'b0;
    #1;
    total++;
    if (ov4 !== 1'b0 || oj4 !== 3'd0 || oc4 !== 10'd0) begin
      bad++;
      $display("FAIL rst_search: got valid=%0b job=%0d cost=%0d want 0 0 0", ov4, oj4, oc4);
    end
    @(negedge clk);
    rst4_n = 1'b1;
    expect_quiet(1, 40, "rst_search");

    // Reset while a result is streaming must clear outputs without a clock edge.
    fill_random(4, 127);
    drive_matrix(1, 4, 1'b1, 16);
    @(posedge clk);
    @(negedge clk);
    iv[1] = 1'b0;
    c = 0;
    while (!ov4 && c < 60) begin
      @(negedge clk);
      c++;
    end
    #2 rst4_n = 1'b0;
    #1;
    total++;
    if (c >= 60 || ov4 !== 1'b0 || oj4 !== 3'd0 || oc4 !== 10'd0) begin
      bad++;
      $display("FAIL rst_out: got valid=%0b job=%0d cost=%0d waited=%0d want 0 0 0",
               ov4, oj4, oc4, c);
    end
    @(negedge clk);
    rst4_n = 1'b1;
    expect_quiet(1, 40, "rst_out");
    fill_random(4, 127);
    run_job(1, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    fill_random(4, 127);
    run_job(1, 1'b0, "b2b_min");
    fill_random(4, 127);
    run_job(1, 1'b1, "b2b_max");
    fill_random(3, 3);
    run_job(2, 1'b0, "b2b3_min");
    fill_random(3, 127);
    run_job(2, 1'b1, "b2b3_max");
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    iv = '0; im = '0; ic = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1; rst4_n = 1'b1;
    @(negedge clk);
    test_max3();
    test_random();
    test_back_to_back();
    test_reset_mid_search();
    test_diag8();
    test_abort_then_uniform8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
